// File: rtl/spi_master_ctrl.sv
// SPI master: serialises {cmd_type, cmd_payload} frames MSB first and, for read-data, captures one byte from MISO.
// Latency: SS_n falls the cycle after accept; a read-data frame returns rd_data 10 + TURNAROUND + 8 cycles after that.
// Backpressure: cmd_ready is high only in IDLE, so a host holding cmd_valid waits until the previous frame and its gap finish.
module spi_master_ctrl #(
    parameter int TURNAROUND = 2,
    parameter int MIN_GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_payload,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, GAP} state_t;

    localparam logic [3:0] TA_LAST  = 4'(TURNAROUND - 1);
    localparam logic [3:0] GAP_LAST = 4'(MIN_GAP - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [9:0] frame, frame_nxt;
    logic [7:0] shift, shift_nxt;
    logic [7:0] rd_data_nxt;
    logic       rd_valid_nxt;
    logic       ss_n_nxt;
    logic       mosi_nxt;

    // Ready is withheld during reset so nothing can be accepted on a reset edge.
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Next-state and next-value logic for the state machine, counter and the registered pins.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        frame_nxt    = frame;
        shift_nxt    = shift;
        rd_data_nxt  = rd_data;
        rd_valid_nxt = 1'b0;
        ss_n_nxt     = 1'b1;
        mosi_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = SEND;
                    frame_nxt = {cmd_type, cmd_payload};
                    cnt_nxt   = 4'd0;
                    ss_n_nxt  = 1'b0;
                    mosi_nxt  = cmd_type[1];
                end
            end
            SEND: begin
                // cnt counts bits already on the wire; bit 9-cnt is being driven now.
                ss_n_nxt = 1'b0;
                if (cnt == 4'd9) begin
                    cnt_nxt = 4'd0;
                    if (frame[9:8] == 2'b11) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = GAP;
                        ss_n_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt  = cnt + 4'd1;
                    mosi_nxt = frame[4'd8 - cnt];
                end
            end
            WAIT: begin
                ss_n_nxt = 1'b0;
                if (cnt == TA_LAST) begin
                    state_nxt = RECV;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            RECV: begin
                // Shift left so the first MISO sample ends up in bit 7.
                ss_n_nxt  = 1'b0;
                shift_nxt = {shift[6:0], MISO};
                if (cnt == 4'd7) begin
                    rd_data_nxt  = {shift[6:0], MISO};
                    rd_valid_nxt = 1'b1;
                    state_nxt    = GAP;
                    cnt_nxt      = 4'd0;
                    ss_n_nxt     = 1'b1;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter, frame/shift storage and registered output pins; reset discards any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            frame    <= 10'd0;
            shift    <= 8'h00;
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            frame    <= frame_nxt;
            shift    <= shift_nxt;
            rd_data  <= rd_data_nxt;
            rd_valid <= rd_valid_nxt;
            SS_n     <= ss_n_nxt;
            MOSI     <= mosi_nxt;
        end
    end

endmodule
